// File: rtl/alu_pkg.sv
// Shared types and constants for the slice-serial ALU.
// Op encodings follow {invert_b, func[1:0]}.
package alu_pkg;

  localparam int DEFAULT_SLICE = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_sum(input logic [2:0] op);
    return op[1:0] == 2'b10;
  endfunction

  function automatic logic is_slt(input logic [2:0] op);
    return op[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-wide ALU bit-slice: ripple adder plus logic ops.
// The adder chain always runs so carry-out is defined for every op.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] res,
  output logic             cout,
  output logic             msb_cin
);

  logic [SLICE-1:0] bx;
  logic [SLICE-1:0] sum;
  logic [SLICE:0]   c;

  always_comb begin
    bx   = op[2] ? ~b : b;
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout    = c[SLICE];
  assign msb_cin = c[SLICE-1];

  // SLT slices pass the raw sum; the MSB fix-up happens at the top.
  always_comb begin
    res = sum;
    unique case (1'b1)
      op[1:0] == 2'b00: res = a & bx;
      op[1:0] == 2'b01: res = a | bx;
      op[1:0] == 2'b10: res = sum;
      op[1:0] == 2'b11: res = sum;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Slice-serial ALU: one alu_slice reused for WIDTH/SLICE cycles,
// then a finalize cycle computes SLT, flags and out_valid.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state;
  logic             armed;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             msb_c;
  logic             valid_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [31:0]      base;
  logic [SLICE-1:0] s_a;
  logic [SLICE-1:0] s_b;
  logic [SLICE-1:0] s_res;
  logic             s_cout;
  logic             s_msb;
  logic             ovf_raw;
  logic             slt_bit;
  logic [WIDTH-1:0] res_fin;

  always_comb base = 32'(idx) * 32'(SLICE);

  assign s_a = a_q[base +: SLICE];
  assign s_b = b_q[base +: SLICE];

  alu_slice #(
    .SLICE(SLICE)
  ) u_slice (
    .a      (s_a),
    .b      (s_b),
    .cin    (carry),
    .op     (op_q),
    .res    (s_res),
    .cout   (s_cout),
    .msb_cin(s_msb)
  );

  // After the last slice, carry holds the MSB carry-out.
  assign ovf_raw = msb_c ^ carry;
  assign slt_bit = res_q[WIDTH-1] ^ ovf_raw;
  assign res_fin = is_slt(op_q) ? WIDTH'(slt_bit) : res_q;

  // armed keeps in_ready low until the first edge after reset.
  assign in_ready  = (state == IDLE) && armed;
  assign out_valid = valid_q;
  assign result    = res_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      armed   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      msb_c   <= 1'b0;
      valid_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            res_q  <= '0;
            idx    <= '0;
            carry  <= op[2];
            msb_c  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          res_q[base +: SLICE] <= s_res;
          carry <= s_cout;
          msb_c <= s_msb;
          idx   <= idx + 1'b1;
          if (idx == LAST) state <= DONE;
        end
        DONE: begin
          if (!valid_q) begin
            res_q   <= res_fin;
            cout_q  <= carry;
            ovf_q   <= is_sum(op_q) & ovf_raw;
            zero_q  <= (res_fin == '0);
            valid_q <= 1'b1;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq (WIDTH=16, SLICE=4).
// Table-driven ops plus hold, back-to-back and mid-op reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        zero;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  alu_seq #(
    .WIDTH(16),
    .SLICE(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                        input logic [2:0] vop, input int hold,
                        output logic [15:0] r, output logic co,
                        output logic ov, output logic z, output int lat);
    bit got;
    r = 'x; co = 'x; ov = 'x; z = 'x; lat = -1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check("ready_timeout", 0, 1);
      return;
    end
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // garbage while busy must be ignored
    a = ~va; b = ~vb; op = ~vop;
    got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin lat = k; got = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!got) begin
      check("valid_timeout", 0, 1);
      return;
    end
    r = result; co = cout; ov = overflow; z = zero;
    check("ready_low_in_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_result", result, r);
      check("hold_flags", {cout, overflow, zero}, {co, ov, z});
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", out_valid, 0);
    check("ready_next", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic        co, ov, z;
    int          lat;

    vecs[0]  = '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0005, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h8000, 16'h0001, OP_SLT, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'h0001, 16'h8000, OP_SLT, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{16'hF0F0, 16'h3C3C, OP_AND, 16'h3030, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{16'hF0F0, 16'h3C3C, OP_OR,  16'hFCFC, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h0003, 16'h0004, OP_ADD, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{16'hF0F0, 16'h3C3C, 3'b100, 16'hC0C0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{16'h0000, 16'hFFFF, 3'b101, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{16'hFFFF, 16'h0000, 3'b011, 16'h0001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {cout, overflow, zero}, 0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_edge", in_ready, 1);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, r, co, ov, z, lat);
      check($sformatf("v%0d_result", i), r, vecs[i].res);
      check($sformatf("v%0d_cout", i), co, vecs[i].co);
      check($sformatf("v%0d_overflow", i), ov, vecs[i].ov);
      check($sformatf("v%0d_zero", i), z, vecs[i].z);
      check($sformatf("v%0d_latency", i), lat, 5);
    end

    run_op(16'h1234, 16'h1111, OP_ADD, 3, r, co, ov, z, lat);
    check("hold_op_result", r, 16'h2345);
    check("hold_op_flags", {co, ov, z}, 3'b000);

    // reset in the second BUSY cycle
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op = OP_ADD; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("partial_slice0", result, 16'h0003);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    run_op(16'h0003, 16'h0004, OP_ADD, 0, r, co, ov, z, lat);
    check("post_rst_result", r, 16'h0007);
    check("post_rst_flags", {co, ov, z}, 3'b000);
    check("post_rst_latency", lat, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
